beep_scheduler: RTL and testbench

Sequences the dual-tone beeper by driving its open512/open1k tone enables. It arbitrates between two requesters: the hourly chime and the alarm. It plays a fixed chime pattern (4 low beeps then 1 high beep) or a repeating alarm pattern. The block sits between the timekeeping/alarm-compare logic and the beeper, in the system clock domain, and is paced by a 10 Hz strobe.

---
 rtl/beep_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_beep_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/beep_scheduler.sv
// Dual-tone beeper sequencer: plays the hourly chime (low beeps then a high
// beep) or the repeating alarm pattern, with the alarm taking priority.
// Ports:
//   clk, rst (async, active-low), tick_10hz (100 ms strobe)
//   chime_req, alarm_req (1-clk pulses), alarm_stop (level or pulse)
//   open512, open1k (registered tone enables), busy, src[1:0],
//   alarm_timeout (1-clk pulse when the alarm ends by cycle expiry)
module beep_scheduler #(
    parameter int unsigned LOW_ON_TICKS  = 5,
    parameter int unsigned LOW_OFF_TICKS = 5,
    parameter int unsigned LOW_BEEPS     = 4,
    parameter int unsigned HIGH_TICKS    = 10,
    parameter int unsigned AL_ON_TICKS   = 5,
    parameter int unsigned AL_OFF_TICKS  = 5,
    parameter int unsigned AL_CYCLES     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_10hz,
    input  logic       chime_req,
    input  logic       alarm_req,
    input  logic       alarm_stop,
    output logic       open512,
    output logic       open1k,
    output logic       busy,
    output logic [1:0] src,
    output logic       alarm_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        CH_LO_ON,
        CH_LO_OFF,
        CH_HI,
        AL_ON,
        AL_OFF
    } state_t;

    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_CHIME = 2'b01;
    localparam logic [1:0] SRC_ALARM = 2'b10;

    state_t     state_q, state_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic [3:0] beep_cnt_q, beep_cnt_d;
    logic [7:0] cyc_cnt_q, cyc_cnt_d;
    logic       open512_q, open512_d;
    logic       open1k_q, open1k_d;
    logic       busy_q, busy_d;
    logic [1:0] src_q, src_d;
    logic       timeout_q, timeout_d;

    logic [7:0] phase_last;
    logic       expire;
    logic       alarm_go;

    // Tick count at which the current phase ends on the next tick.
    always_comb begin
        phase_last = 8'd0;
        unique case (state_q)
            CH_LO_ON:  phase_last = 8'(LOW_ON_TICKS - 1);
            CH_LO_OFF: phase_last = 8'(LOW_OFF_TICKS - 1);
            CH_HI:     phase_last = 8'(HIGH_TICKS - 1);
            AL_ON:     phase_last = 8'(AL_ON_TICKS - 1);
            AL_OFF:    phase_last = 8'(AL_OFF_TICKS - 1);
            default:   phase_last = 8'd0;
        endcase
    end

    assign expire   = tick_10hz && (tick_cnt_q == phase_last);
    assign alarm_go = alarm_req && !alarm_stop;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        beep_cnt_d = beep_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (alarm_go) begin
                    state_d    = AL_ON;
                    cyc_cnt_d  = 8'd0;
                    tick_cnt_d = 8'd0;
                end else if (chime_req) begin
                    state_d    = CH_LO_ON;
                    beep_cnt_d = 4'd0;
                    tick_cnt_d = 8'd0;
                end
            end
            CH_LO_ON, CH_LO_OFF, CH_HI: begin
                if (alarm_go) begin
                    state_d    = AL_ON;
                    cyc_cnt_d  = 8'd0;
                    tick_cnt_d = 8'd0;
                end else if (expire) begin
                    tick_cnt_d = 8'd0;
                    if (state_q == CH_LO_ON) begin
                        state_d = CH_LO_OFF;
                    end else if (state_q == CH_LO_OFF) begin
                        beep_cnt_d = beep_cnt_q + 4'd1;
                        if (beep_cnt_d == 4'(LOW_BEEPS)) state_d = CH_HI;
                        else state_d = CH_LO_ON;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tick_10hz) begin
                    tick_cnt_d = tick_cnt_q + 8'd1;
                end
            end
            AL_ON, AL_OFF: begin
                if (alarm_stop) begin
                    state_d    = IDLE;
                    tick_cnt_d = 8'd0;
                end else if (expire) begin
                    tick_cnt_d = 8'd0;
                    if (state_q == AL_ON) begin
                        state_d = AL_OFF;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 8'd1;
                        if (cyc_cnt_d == 8'(AL_CYCLES)) begin
                            state_d   = IDLE;
                            timeout_d = 1'b1;
                        end else begin
                            state_d = AL_ON;
                        end
                    end
                end else if (tick_10hz) begin
                    tick_cnt_d = tick_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch with it.
    always_comb begin
        open512_d = (state_d == CH_LO_ON);
        open1k_d  = (state_d == CH_HI) || (state_d == AL_ON);
        busy_d    = (state_d != IDLE);
        src_d     = SRC_NONE;
        if (state_d == AL_ON || state_d == AL_OFF) src_d = SRC_ALARM;
        else if (state_d != IDLE) src_d = SRC_CHIME;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= 8'd0;
            beep_cnt_q <= 4'd0;
            cyc_cnt_q  <= 8'd0;
            open512_q  <= 1'b0;
            open1k_q   <= 1'b0;
            busy_q     <= 1'b0;
            src_q      <= SRC_NONE;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            beep_cnt_q <= beep_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            open512_q  <= open512_d;
            open1k_q   <= open1k_d;
            busy_q     <= busy_d;
            src_q      <= src_d;
            timeout_q  <= timeout_d;
        end
    end

    assign open512       = open512_q;
    assign open1k        = open1k_q;
    assign busy          = busy_q;
    assign src           = src_q;
    assign alarm_timeout = timeout_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Bench for beep_scheduler: per-cycle scoreboard fed by a phase-list model
// of the chime/alarm patterns, with directed scenarios and random requests.
module tb_beep_scheduler;

    localparam int AL_CYC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_10hz = 1'b0;
    logic       chime_req = 1'b0;
    logic       alarm_req = 1'b0;
    logic       alarm_stop = 1'b0;
    logic       open512, open1k, busy, alarm_timeout;
    logic [1:0] src;

    beep_scheduler #(.AL_CYCLES(AL_CYC)) dut (
        .clk(clk), .rst(rst), .tick_10hz(tick_10hz),
        .chime_req(chime_req), .alarm_req(alarm_req),
        .alarm_stop(alarm_stop), .open512(open512), .open1k(open1k),
        .busy(busy), .src(src), .alarm_timeout(alarm_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       o512;
        logic       o1k;
        logic       busy;
        logic [1:0] src;
        logic       tmo;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   tdiv = 0;

    // Model: the active pattern is a list of (tone, length) phases.
    // tone 0 silent, 1 = 512 Hz, 2 = 1 kHz. mode 0 idle, 1 chime, 2 alarm.
    int ph_tone[$];
    int ph_len[$];
    int mode = 0;
    int pcnt = 0;
    bit m_tmo = 0;

    function automatic void load_chime();
        ph_tone.delete(); ph_len.delete();
        for (int i = 0; i < 4; i++) begin
            ph_tone.push_back(1); ph_len.push_back(5);
            ph_tone.push_back(0); ph_len.push_back(5);
        end
        ph_tone.push_back(2); ph_len.push_back(10);
        mode = 1; pcnt = 0;
    endfunction

    function automatic void load_alarm();
        ph_tone.delete(); ph_len.delete();
        for (int i = 0; i < AL_CYC; i++) begin
            ph_tone.push_back(2); ph_len.push_back(5);
            ph_tone.push_back(0); ph_len.push_back(5);
        end
        mode = 2; pcnt = 0;
    endfunction

    function automatic void advance();
        pcnt++;
        if (pcnt == ph_len[0]) begin
            void'(ph_tone.pop_front());
            void'(ph_len.pop_front());
            pcnt = 0;
            if (ph_len.size() == 0) begin
                if (mode == 2) m_tmo = 1;
                mode = 0;
            end
        end
    endfunction

    function automatic void model(bit t, bit c, bit a, bit s);
        m_tmo = 0;
        if (mode == 2) begin
            if (s) mode = 0;
            else if (t) advance();
        end else if (mode == 1) begin
            if (a && !s) load_alarm();
            else if (t) advance();
        end else begin
            if (a && !s) load_alarm();
            else if (c) load_chime();
        end
    endfunction

    function automatic int cur_tone();
        return (mode != 0) ? ph_tone[0] : 0;
    endfunction

    function automatic exp_t expected();
        exp_t e;
        e.o512 = (cur_tone() == 1);
        e.o1k  = (cur_tone() == 2);
        e.busy = (mode != 0);
        e.src  = (mode == 1) ? 2'b01 : (mode == 2) ? 2'b10 : 2'b00;
        e.tmo  = m_tmo;
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, model the coming edge.
    task automatic cyc(input bit c, input bit a, input bit s);
        bit t;
        @(negedge clk);
        t = (tdiv == 9);
        tdiv = t ? 0 : tdiv + 1;
        tick_10hz  = t;
        chime_req  = c;
        alarm_req  = a;
        alarm_stop = s;
        model(t, c, a, s);
        expq.push_back(expected());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0);
    endtask

    // Monitor: compare the DUT just after each active edge.
    always @(posedge clk) begin
        exp_t e;
        exp_t act;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            act = {open512, open1k, busy, src, alarm_timeout};
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL outputs t=%0t got o512/o1k/busy/src/tmo=%b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         $time, open512, open1k, busy, src, alarm_timeout,
                         e.o512, e.o1k, e.busy, e.src, e.tmo);
            end
            tests++;
            if (open512 && open1k) begin
                fails++;
                $display("FAIL tone_excl t=%0t got both high want at most one", $time);
            end
        end
    end

    task automatic wait_model(input string nm, input int want_size, input int want_tone);
        int n = 0;
        while (!(mode != 0 && ph_len.size() == want_size && cur_tone() == want_tone) && n < 3000) begin
            cyc(0, 0, 0);
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s timeout got phases=%0d want %0d", nm, ph_len.size(), want_size);
        end
    endtask

    initial begin
        #1;
        tests++;
        if ({open512, open1k, busy, src, alarm_timeout} !== 6'b0) begin
            fails++;
            $display("FAIL reset_state got %b want 000000",
                     {open512, open1k, busy, src, alarm_timeout});
        end
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // Full chime with default timing.
        cyc(1, 0, 0);
        idle(560);

        // Alarm runs three cycles then times out.
        cyc(0, 1, 0);
        idle(340);

        // Alarm preempts a chime during the second low-beep gap.
        cyc(1, 0, 0);
        wait_model("chime_beep2_off", 6, 0);
        idle(17);
        cyc(0, 1, 0);
        idle(30);
        cyc(0, 0, 1);
        idle(300);

        // Simultaneous alarm and chime; chime during alarm gap.
        cyc(1, 1, 0);
        wait_model("alarm_off", 5, 0);
        idle(12);
        cyc(1, 0, 0);
        idle(20);
        cyc(0, 0, 1);
        idle(100);

        // Stop two ticks into AL_ON; request with stop stays idle.
        cyc(0, 1, 0);
        idle(22);
        cyc(0, 0, 1);
        idle(50);
        cyc(0, 1, 1);
        idle(30);

        // Asynchronous reset during the high beep.
        cyc(1, 0, 0);
        wait_model("chime_hi", 1, 2);
        idle(25);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({open512, open1k, busy, src, alarm_timeout} !== 6'b0) begin
            fails++;
            $display("FAIL async_reset got %b want 000000",
                     {open512, open1k, busy, src, alarm_timeout});
        end
        mode = 0; pcnt = 0; m_tmo = 0;
        ph_tone.delete(); ph_len.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(100);

        // Random request traffic.
        for (int i = 0; i < 15000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 599) == 0,
                $urandom_range(0, 799) == 0);
        end
        idle(3);
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
